// File: rtl/apb_slave_regfile.sv
// APB3 completer hosting a small word register bank: read-only ID and error
// counter, read/write control registers, programmable wait states and PSLVERR.
module apb_slave_regfile #(
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = 32'hA11B_0001
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic [31:0] ctrl_out
);

   localparam logic [9:0] LP_NREGS = 10'(NUM_REGS);
   localparam logic [3:0] LP_WS    = 4'(WAIT_STATES);

   typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

   state_t      r_state, w_state_nxt;
   logic [9:0]  r_idx;
   logic        r_write, r_err;
   logic [31:0] r_wdata;
   logic [3:0]  r_cnt;
   logic [15:0] r_errcnt;
   logic [31:0] r_regs [2:NUM_REGS-1];

   logic        w_setup, w_access, w_ready, w_err_in;
   logic [9:0]  w_idx;
   logic [31:0] w_rdval;
   logic        w_unused;

   assign w_unused = ^PADDR[31:12];
   assign w_idx    = PADDR[11:2];
   assign w_setup  = PSEL & ~PENABLE;
   assign w_access = PSEL & PENABLE;
   assign w_err_in = (w_idx >= LP_NREGS) || (PADDR[1:0] != 2'b00) ||
                     (PWRITE && (w_idx < 10'd2));
   assign w_ready  = (r_state == ST_ACCESS) && w_access && (r_cnt == 4'd0);

   // A setup seen while in ACCESS (abort) simply restarts the transfer.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_setup) w_state_nxt = ST_ACCESS;
         ST_ACCESS: begin
            if (w_access) begin
               if (r_cnt == 4'd0) w_state_nxt = ST_IDLE;
            end else if (w_setup) begin
               w_state_nxt = ST_ACCESS;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_idx   <= '0;
         r_write <= 1'b0;
         r_wdata <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else if (w_setup) begin
         r_idx   <= w_idx;
         r_write <= PWRITE;
         r_wdata <= PWDATA;
         r_err   <= w_err_in;
         r_cnt   <= LP_WS;
      end else if ((r_state == ST_ACCESS) && w_access && (r_cnt != 4'd0)) begin
         r_cnt   <= r_cnt - 4'd1;
      end
   end

   // Commit uses latched address/data so bus wiggles during wait states are harmless.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_errcnt <= '0;
         for (int i = 2; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (w_ready) begin
         if (r_err) begin
            if (r_errcnt != 16'hFFFF) r_errcnt <= r_errcnt + 16'd1;
         end else if (r_write) begin
            for (int i = 2; i < NUM_REGS; i++)
               if (r_idx == 10'(i)) r_regs[i] <= r_wdata;
         end
      end
   end

   always_comb begin
      w_rdval = '0;
      if (r_idx == 10'd0) w_rdval = ID_VALUE;
      if (r_idx == 10'd1) w_rdval = {16'h0000, r_errcnt};
      for (int i = 2; i < NUM_REGS; i++)
         if (r_idx == 10'(i)) w_rdval = r_regs[i];
   end

   assign PREADY   = w_ready;
   assign PSLVERR  = w_ready & r_err;
   assign PRDATA   = (w_ready && !r_err && !r_write) ? w_rdval : 32'h0;
   assign ctrl_out = r_regs[2];

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB3 completer (slave) at the far end of the AHB-to-APB bridge: answers the bridge's PSEL/PENABLE/PADDR/PWRITE/PWDATA transfers.
- Contains a small register bank with a configurable number of wait states and error signalling.
- Provides the responder side needed to close the bridge loop in system simulation and to host control/status registers for a peripheral.

Parameters:
- NUM_REGS, 8: number of 32-bit word registers, minimum 3.
- WAIT_STATES, 0: number of PREADY-low access cycles per transfer, range 0..15.
- ID_VALUE, 32'hA11B_0001: value returned by read-only register 0.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- PSEL  in  1  this slave's select bit, one bit of the bridge's PSEL bus
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  32  byte address; word index = PADDR[11:2]
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error response, valid only with PREADY
- ctrl_out  out  32  live contents of register 2

Behaviour:
- Reset (async): state IDLE, wait counter 0, latches 0, registers 2..NUM_REGS-1 = 0, ERRCNT = 0. Outputs are PRDATA=0, PREADY=0, PSLVERR=0, ctrl_out=0.
- Register map:
  - idx0 ID: read-only, returns ID_VALUE.
  - idx1 ERRCNT: read-only. Bits [15:0] hold a saturating count of PSLVERR responses; bits [31:16] read 0.
  - idx2..NUM_REGS-1: read/write.
- Error cases: idx >= NUM_REGS, PADDR[1:0] != 0, or a write to idx0/idx1 → PSLVERR=1, no register change, PRDATA=0.
- FSM states:
  - IDLE: PREADY=0. On PSEL=1 and PENABLE=0 (setup):
    - latch PADDR, PWRITE, PWDATA;
    - compute the error flag;
    - load counter with WAIT_STATES;
    - go to ACCESS.
  - ACCESS, with PSEL=1 and PENABLE=1:
    - PREADY = (counter==0). Counter decrements each cycle while nonzero.
    - With WAIT_STATES=0, PREADY=1 in the first access cycle, giving a 2-cycle transfer. Total transfer = 2 + WAIT_STATES cycles.
    - In the PREADY=1 cycle: PSLVERR = latched error flag; PRDATA = selected register for a read with no error, otherwise 0.
    - A write commits at the HCLK edge closing the PREADY=1 cycle. ERRCNT increments (saturating at 16'hFFFF) at that same edge when the error flag is set.
    - Next state:
      - IDLE after completion;
      - ACCESS again (back-to-back) if the completion cycle is immediately followed by a new setup. Back-to-back is detected in the following cycle as PSEL=1, PENABLE=0 while in IDLE; no extra idle cycle is required.
- Abort: in ACCESS, PSEL=0 or PENABLE=0 before PREADY → immediate return to IDLE.
  - No write, no ERRCNT change, PREADY stays 0.
  - If the abort cycle is itself a setup (PSEL=1, PENABLE=0), treat it as a new setup and re-enter ACCESS.
- PRDATA and PSLVERR are 0 whenever PREADY=0. PRDATA is combinational from latched index; PREADY is combinational from state and counter.
- Latched PADDR/PWDATA are used for commit, so bus changes during wait states do not affect the transfer.
- ctrl_out reflects register 2 from the cycle after the committing edge.
- HRESETn asserted mid-transfer: immediate reset values; the pending write is lost.

Test Plan:
- Write then read, WAIT_STATES=0: write PADDR=0x008, PWDATA=0xDEADBEEF → PREADY=1 on 2nd cycle, PSLVERR=0, ctrl_out=0xDEADBEEF. Read 0x008 → PRDATA=0xDEADBEEF with PREADY.
- Wait states, WAIT_STATES=3: read 0x000 → PREADY low for 3 access cycles, high on the 4th with PRDATA=0xA11B0001. The transfer spans 5 cycles total.
- Errors:
  - write 0x004 → PSLVERR=1;
  - read 0x020 (NUM_REGS=8) → PSLVERR=1, PRDATA=0;
  - write 0x00A (misaligned) → PSLVERR=1, reg2 unchanged.
  - Then read 0x004 → PRDATA=3.
- Back-to-back writes to 0x00C (0x1) and 0x010 (0x2) with no idle cycle, WAIT_STATES=1 → each completes in 3 cycles; readback gives 0x1 and 0x2.
- Abort and reset, WAIT_STATES=2:
  - write 0x008 = 0x55 and drop PSEL after the 1st access cycle → reg2 unchanged, ERRCNT unchanged.
  - Assert HRESETn low during the wait of a write → PREADY=0 immediately; reg2=0 and ctrl_out=0 after release.
